// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared definitions for the MEM-stage load/store unit:
//             RV32I load/store funct3 codes, the RMW state type and the
//             access-alignment helper.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // RV32I load/store width and sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size as encoded in funct3[1:0]
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Read-modify-write sequencer states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } mau_state_t;

    // An access is misaligned when its low address bits do not fit its size.
    // Size code 11 does not exist in RV32I and is rejected as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] byte_off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = byte_off[0];
            SZ_WORD: bad = (byte_off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : load_align
//  Purpose  : Combinational lane selection and extension for sub-word loads,
//             plus the byte-lane mask of the addressed bytes (used by the
//             store path to merge sub-word data into a read word).
//  Ports    : word      - full 32-bit word read from memory
//             byte_off  - addr[1:0] of the access
//             funct3    - RV32I load/store width and sign code
//             load_data - selected, extended load result
//             lane_mask - one bit per byte lane touched by the access
//  Revision : 1.0 - initial release
// ============================================================================
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [3:0]  lane_mask
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = 8'h00;
        case (byte_off)
            2'd0: sel_byte = word[7:0];
            2'd1: sel_byte = word[15:8];
            2'd2: sel_byte = word[23:16];
            2'd3: sel_byte = word[31:24];
            default: sel_byte = 8'h00;
        endcase
        sel_half = byte_off[1] ? word[31:16] : word[15:0];
    end

    // funct3[2] set selects zero extension (LBU/LHU)
    always_comb begin
        load_data = 32'h0;
        lane_mask = 4'b0000;
        case (funct3[1:0])
            SZ_BYTE: begin
                load_data = funct3[2] ? {24'h0, sel_byte}
                                      : {{24{sel_byte[7]}}, sel_byte};
                lane_mask = 4'b0001 << byte_off;
            end
            SZ_HALF: begin
                load_data = funct3[2] ? {16'h0, sel_half}
                                      : {{16{sel_half[15]}}, sel_half};
                lane_mask = byte_off[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                load_data = word;
                lane_mask = 4'b1111;
            end
            default: begin
                load_data = 32'h0;
                lane_mask = 4'b0000;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : MEM-stage load/store unit in front of a word-addressable data
//             memory. Loads are zero-latency with lane select and extension;
//             SW is a single write; SB/SH are a two-cycle read-modify-write
//             that stalls the pipeline for the read cycle. Misaligned
//             accesses are suppressed and recorded in a sticky fault bit.
//  Ports    : clk, rst_n           - clock, async active-low reset
//             valid_in, mem_read,
//             mem_write, funct3,
//             addr, store_data     - MEM-stage request
//             load_data            - extended load result to WB
//             stall                - hold IF/ID/EX/MEM this cycle
//             misaligned, fault    - current / sticky misalignment
//             dm_*                 - data memory interface
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] load_data,
    output logic              stall,
    output logic              misaligned,
    output logic              fault,
    output logic              dm_r_enable,
    output logic              dm_w_enable,
    output logic [ADDR_W-1:0] dm_address,
    output logic [DATA_W-1:0] dm_wr_data,
    input  logic [DATA_W-1:0] dm_re_data
);

    mau_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              fault_q, fault_d;

    logic              is_load;
    logic              is_store;
    logic              addr_bad;
    logic              sub_word;
    logic [ADDR_W-1:0] word_addr;
    logic [DATA_W-1:0] aligned_load;
    logic [3:0]        lane_mask;
    logic [DATA_W-1:0] lane_bits;
    logic [DATA_W-1:0] store_rep;
    logic [DATA_W-1:0] merged_word;

    // A request with both read and write set is a store.
    assign is_load   = valid_in & mem_read & ~mem_write;
    assign is_store  = valid_in & mem_write;
    assign addr_bad  = is_misaligned(funct3[1:0], addr[1:0]);
    assign sub_word  = (funct3[1] == 1'b0);
    assign word_addr = {addr[ADDR_W-1:2], 2'b00};

    // Lane decode is shared between the load extractor and the store merge
    load_align u_load_align (
        .word      (dm_re_data),
        .byte_off  (addr[1:0]),
        .funct3    (funct3),
        .load_data (aligned_load),
        .lane_mask (lane_mask)
    );

    // Replicate store data across all lanes, then keep only addressed lanes
    always_comb begin
        store_rep = (funct3[1:0] == SZ_HALF) ? {2{store_data[15:0]}}
                                             : {4{store_data[7:0]}};
        lane_bits = '0;
        for (int i = 0; i < 4; i++) begin
            lane_bits[8*i +: 8] = {8{lane_mask[i]}};
        end
        merged_word = (dm_re_data & ~lane_bits) | (store_rep & lane_bits);
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        misaligned  = 1'b0;
        stall       = 1'b0;
        dm_r_enable = 1'b0;
        dm_w_enable = 1'b0;
        dm_address  = word_addr;
        dm_wr_data  = '0;
        load_data   = '0;

        if (state_q == WRITE) begin
            // Second RMW cycle: request inputs are still the same store and
            // are deliberately ignored so the access is not restarted.
            dm_w_enable = 1'b1;
            dm_address  = addr_q;
            dm_wr_data  = wdata_q;
            state_d     = IDLE;
        end else if (is_load | is_store) begin
            if (addr_bad) begin
                misaligned = 1'b1;
            end else if (is_store) begin
                if (sub_word) begin
                    stall       = 1'b1;
                    dm_r_enable = 1'b1;
                    addr_d      = word_addr;
                    wdata_d     = merged_word;
                    state_d     = WRITE;
                end else begin
                    dm_w_enable = 1'b1;
                    dm_wr_data  = store_data;
                end
            end else begin
                dm_r_enable = 1'b1;
                load_data   = aligned_load;
            end
        end

        fault_d = fault_q | misaligned;

        // While reset is held the pipeline is being flushed: no memory
        // traffic and no stall, even if a request is still presented.
        if (!rst_n) begin
            stall       = 1'b0;
            dm_r_enable = 1'b0;
            dm_w_enable = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Self-checking bench for mem_access_unit: directed load table,
//             hand-written RMW / misalignment / reset sequences, and random
//             requests checked against a byte-array reference memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [31:0] load_data;
    logic        stall, misaligned, fault;
    logic        dm_r_enable, dm_w_enable;
    logic [31:0] dm_address, dm_wr_data, dm_re_data;

    // Data memory: 64 words, combinational read
    logic [31:0] mem [64];
    logic        pl_en  = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_val = 32'h0;
    int          wr_count = 0;

    // Reference memory as bytes
    logic [7:0]  rmem [256];
    logic        exp_fault;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .addr        (addr),
        .store_data  (store_data),
        .load_data   (load_data),
        .stall       (stall),
        .misaligned  (misaligned),
        .fault       (fault),
        .dm_r_enable (dm_r_enable),
        .dm_w_enable (dm_w_enable),
        .dm_address  (dm_address),
        .dm_wr_data  (dm_wr_data),
        .dm_re_data  (dm_re_data)
    );

    assign dm_re_data = mem[dm_address[7:2]];

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (dm_w_enable) begin
            mem[dm_address[7:2]] <= dm_wr_data;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0b expected=%0b", name, act, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
        valid_in = v; mem_read = rd; mem_write = wr;
        funct3 = f3; addr = a; store_data = sd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] ba, input logic [31:0] w);
        int base;
        base = int'(ba) & ~3;
        pl_en = 1'b1; pl_idx = ba[7:2]; pl_val = w;
        for (int k = 0; k < 4; k++) rmem[base + k] = 8'(w >> (8 * k));
        next_cycle();
        pl_en = 1'b0;
    endtask

    function automatic logic [31:0] ref_word(input int ba);
        logic [31:0] r;
        int base;
        base = ba & ~3;
        r = 32'h0;
        for (int k = 0; k < 4; k++) r = r | (32'(rmem[base + k]) << (8 * k));
        return r;
    endfunction

    // One request checked against the byte-level reference. Entered and
    // left one time unit after a rising edge.
    task automatic model_op(input logic v, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
        logic ld, st, bad, sub_st, word_st;
        int ba, nbytes;
        longint lv;
        logic [31:0] exp_ld;
        ld = v & rd & ~wr;
        st = v & wr;
        case (f3[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = a[0];
            2'b10:   bad = (a[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        ba      = int'(a[7:0]);
        nbytes  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        sub_st  = st && !bad && (nbytes < 4);
        word_st = st && !bad && (nbytes == 4);
        exp_ld  = 32'h0;
        if (ld && !bad) begin
            lv = 0;
            for (int k = 0; k < nbytes; k++) lv += longint'(rmem[ba + k]) << (8 * k);
            if (!f3[2] && nbytes < 4 && lv >= (longint'(1) << (8 * nbytes - 1)))
                lv -= (longint'(1) << (8 * nbytes));
            exp_ld = 32'(lv);
        end
        set_in(v, rd, wr, f3, a, sd);
        @(negedge clk);
        chk1("fault", fault, exp_fault);
        chk1("misaligned", misaligned, (ld || st) && bad);
        chk1("stall", stall, sub_st);
        chk1("dm_r_enable", dm_r_enable, (ld && !bad) || sub_st);
        chk1("dm_w_enable", dm_w_enable, word_st);
        chk("load_data", load_data, exp_ld);
        if ((ld || st) && !bad) chk("dm_address", dm_address, {a[31:2], 2'b00});
        if (word_st) chk("dm_wr_data", dm_wr_data, sd);
        if ((ld || st) && bad) exp_fault = 1'b1;
        if (st && !bad)
            for (int k = 0; k < nbytes; k++) rmem[ba + k] = 8'(sd >> (8 * k));
        next_cycle();
        if (sub_st) begin
            @(negedge clk);
            chk1("rmw2 stall", stall, 1'b0);
            chk1("rmw2 dm_w_enable", dm_w_enable, 1'b1);
            chk1("rmw2 dm_r_enable", dm_r_enable, 1'b0);
            chk("rmw2 load_data", load_data, 32'h0);
            chk("rmw2 dm_address", dm_address, {a[31:2], 2'b00});
            chk("rmw2 dm_wr_data", dm_wr_data, ref_word(ba));
            next_cycle();
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] exp;
    } load_vec_t;

    initial begin
        load_vec_t lv_tab [8];
        int        w0;
        logic [2:0] f3_list [7];
        logic [31:0] ra;
        logic v, rd, wr;

        lv_tab[0] = '{F3_B,  32'h20, 32'hFFFF_FFEF};
        lv_tab[1] = '{F3_BU, 32'h21, 32'h0000_00BE};
        lv_tab[2] = '{F3_H,  32'h22, 32'hFFFF_DEAD};
        lv_tab[3] = '{F3_HU, 32'h22, 32'h0000_DEAD};
        lv_tab[4] = '{F3_W,  32'h20, 32'hDEAD_BEEF};
        lv_tab[5] = '{F3_B,  32'h23, 32'hFFFF_FFDE};
        lv_tab[6] = '{F3_BU, 32'h20, 32'h0000_00EF};
        lv_tab[7] = '{F3_H,  32'h20, 32'hFFFF_BEEF};

        f3_list[0] = F3_B;  f3_list[1] = F3_H;  f3_list[2] = F3_W;
        f3_list[3] = F3_BU; f3_list[4] = F3_HU; f3_list[5] = 3'b011;
        f3_list[6] = 3'b111;

        for (int i = 0; i < 256; i++) rmem[i] = 8'h00;
        exp_fault = 1'b0;

        // Reset with a store presented: no write, no stall
        rst_n = 1'b0;
        set_in(1'b1, 1'b0, 1'b1, F3_B, 32'h24, 32'h1111_1111);
        #1;
        chk1("reset stall", stall, 1'b0);
        chk1("reset dm_w_enable", dm_w_enable, 1'b0);
        chk1("reset fault", fault, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, F3_B, 32'h0, 32'h0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Directed loads over 0xDEADBEEF
        preload(8'h20, 32'hDEAD_BEEF);
        foreach (lv_tab[i]) begin
            set_in(1'b1, 1'b1, 1'b0, lv_tab[i].f3, lv_tab[i].a, 32'h0);
            @(negedge clk);
            chk("table load_data", load_data, lv_tab[i].exp);
            chk1("table stall", stall, 1'b0);
            chk1("table dm_r_enable", dm_r_enable, 1'b1);
            chk("table dm_address", dm_address, 32'h20);
            next_cycle();
        end

        // SB 0x55 @0x21: one stall cycle, write only in the second cycle
        set_in(1'b1, 1'b0, 1'b1, F3_B, 32'h21, 32'h0000_0055);
        @(negedge clk);
        chk1("sb c1 stall", stall, 1'b1);
        chk1("sb c1 dm_w_enable", dm_w_enable, 1'b0);
        chk1("sb c1 dm_r_enable", dm_r_enable, 1'b1);
        next_cycle();
        @(negedge clk);
        chk1("sb c2 stall", stall, 1'b0);
        chk1("sb c2 dm_w_enable", dm_w_enable, 1'b1);
        chk("sb c2 dm_wr_data", dm_wr_data, 32'hDEAD_55EF);
        next_cycle();
        set_in(1'b0, 1'b0, 1'b0, F3_B, 32'h0, 32'h0);
        @(negedge clk);
        chk("sb mem", mem[8], 32'hDEAD_55EF);
        next_cycle();

        // SH @0x22 then SW @0x24 back to back: exactly two writes
        preload(8'h20, 32'hDEAD_BEEF);
        preload(8'h24, 32'h0000_0000);
        w0 = wr_count;
        set_in(1'b1, 1'b0, 1'b1, F3_H, 32'h22, 32'h0000_1234);
        next_cycle();
        next_cycle();
        set_in(1'b1, 1'b0, 1'b1, F3_W, 32'h24, 32'hCAFE_F00D);
        @(negedge clk);
        chk1("sw stall", stall, 1'b0);
        chk1("sw dm_w_enable", dm_w_enable, 1'b1);
        next_cycle();
        set_in(1'b0, 1'b0, 1'b0, F3_B, 32'h0, 32'h0);
        @(negedge clk);
        chk1("idle dm_w_enable", dm_w_enable, 1'b0);
        next_cycle();
        chk("sh mem", mem[8], 32'h1234_BEEF);
        chk("sw mem", mem[9], 32'hCAFE_F00D);
        chk("write count", 32'(wr_count - w0), 32'd2);

        // Misaligned SH @0x23 then LW @0x26
        preload(8'h20, 32'hDEAD_BEEF);
        preload(8'h24, 32'h0BAD_F00D);
        set_in(1'b1, 1'b0, 1'b1, F3_H, 32'h23, 32'h0000_AAAA);
        @(negedge clk);
        chk1("mis sh misaligned", misaligned, 1'b1);
        chk1("mis sh dm_w_enable", dm_w_enable, 1'b0);
        chk1("mis sh stall", stall, 1'b0);
        chk1("mis sh fault before", fault, 1'b0);
        next_cycle();
        set_in(1'b1, 1'b1, 1'b0, F3_W, 32'h26, 32'h0);
        @(negedge clk);
        chk1("mis lw misaligned", misaligned, 1'b1);
        chk1("mis lw dm_r_enable", dm_r_enable, 1'b0);
        chk("mis lw load_data", load_data, 32'h0);
        chk1("mis fault set", fault, 1'b1);
        next_cycle();
        set_in(1'b0, 1'b0, 1'b0, F3_B, 32'h0, 32'h0);
        next_cycle();
        next_cycle();
        chk1("fault held", fault, 1'b1);
        chk("mis mem 20", mem[8], 32'hDEAD_BEEF);
        chk("mis mem 24", mem[9], 32'h0BAD_F00D);

        // Reset during the WRITE cycle of an SB loses the write
        set_in(1'b1, 1'b0, 1'b1, F3_B, 32'h20, 32'h0000_0077);
        @(negedge clk);
        chk1("rst sb stall", stall, 1'b1);
        next_cycle();
        chk1("rst write cycle dm_w_enable", dm_w_enable, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rst dm_w_enable drop", dm_w_enable, 1'b0);
        chk1("rst stall", stall, 1'b0);
        chk1("rst fault clear", fault, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, F3_B, 32'h0, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst mem", mem[8], 32'hDEAD_BEEF);
        chk1("rst idle dm_w_enable", dm_w_enable, 1'b0);
        next_cycle();
        exp_fault = 1'b0;

        // Resync the whole memory with random contents
        for (int i = 0; i < 64; i++) preload(8'(i * 4), $urandom());

        // valid_in=0 with mem_write, and read+write treated as store
        model_op(1'b0, 1'b0, 1'b1, F3_W, 32'h24, 32'h5555_5555);
        model_op(1'b1, 1'b1, 1'b1, F3_W, 32'h24, 32'h1122_3344);
        model_op(1'b1, 1'b1, 1'b1, F3_B, 32'h29, 32'h0000_00A5);
        chk("rw store mem", mem[9], 32'h1122_3344);

        // Random requests
        for (int n = 0; n < 400; n++) begin
            v  = ($urandom_range(0, 9) != 0);
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            ra = $urandom();
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            model_op(v, rd, wr, f3_list[$urandom_range(0, 6)], ra, $urandom());
        end
        set_in(1'b0, 1'b0, 1'b0, F3_B, 32'h0, 32'h0);
        next_cycle();

        for (int i = 0; i < 64; i++) chk("final mem", mem[i], ref_word(i * 4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
